cajero_arbitro: RTL and testbench

CAJERO_ARBITRO -- requirements
Module: cajero_arbitro

---
 rtl/cajero_pkg.sv | 17 +
 rtl/cajero_arbitro_if.sv | 25 ++
 rtl/cajero_alu.sv | 33 +++
 rtl/cajero_arbitro.sv | 158 +++++++++++++++
 tb/tb_cajero_arbitro.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cajero_pkg.sv
// Shared definitions for the two-terminal cash arbiter: FSM states,
// transaction types and the default grant timeout.
package cajero_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    EXEC    = 2'd2,
    RESP    = 2'd3
  } estado_t;

  localparam logic DEPOSITO = 1'b0;
  localparam logic RETIRO   = 1'b1;

  localparam int TIMEOUT_CICLOS_DEF = 8;

endpackage

// File: rtl/cajero_arbitro_if.sv
// Terminal-side bus of the arbiter: requests/amounts in, grant/response out.
interface cajero_arbitro_if;
  logic [1:0]  REQ;
  logic [1:0]  TIPO_TRANS;
  logic [31:0] MONTO_0;
  logic [31:0] MONTO_1;
  logic [1:0]  MONTO_STB;
  logic        BLOQUEO;
  logic [1:0]  GNT;
  logic [1:0]  DONE;
  logic [31:0] BALANCE;
  logic        FONDOS_INSUFICIENTES;
  logic        DESBORDE;
  logic [1:0]  TIMEOUT;

  modport master (
    output REQ, TIPO_TRANS, MONTO_0, MONTO_1, MONTO_STB, BLOQUEO,
    input  GNT, DONE, BALANCE, FONDOS_INSUFICIENTES, DESBORDE, TIMEOUT
  );

  modport slave (
    input  REQ, TIPO_TRANS, MONTO_0, MONTO_1, MONTO_STB, BLOQUEO,
    output GNT, DONE, BALANCE, FONDOS_INSUFICIENTES, DESBORDE, TIMEOUT
  );
endinterface

// File: rtl/cajero_alu.sv
// Combinational balance arithmetic: deposit with carry detection,
// withdrawal with insufficient-funds detection. A rejected operation
// returns the balance unchanged.
module cajero_alu
  import cajero_pkg::*;
(
  input  logic        tipo,
  input  logic [31:0] monto,
  input  logic [31:0] balance,
  output logic [31:0] nuevo_balance,
  output logic        fondos_insuf,
  output logic        desborde
);

  logic [32:0] suma;

  assign suma = {1'b0, balance} + {1'b0, monto};

  // Select result and rejection flag for the requested operation
  always_comb begin
    nuevo_balance = balance;
    fondos_insuf  = 1'b0;
    desborde      = 1'b0;
    if (tipo == DEPOSITO) begin
      desborde = suma[32];
      if (!suma[32]) nuevo_balance = suma[31:0];
    end else begin
      fondos_insuf = (monto > balance);
      if (monto <= balance) nuevo_balance = balance - monto;
    end
  end

endmodule

// File: rtl/cajero_arbitro.sv
// Round-robin arbiter for two terminals sharing one account balance.
// Flow: IDLE -> GRANTED (wait for strobe / release / timeout) -> EXEC
// (ALU result registered) -> RESP (commit), outputs follow one edge later.
module cajero_arbitro
  import cajero_pkg::*;
#(
  parameter int          TIMEOUT_CICLOS  = TIMEOUT_CICLOS_DEF,
  parameter logic [31:0] BALANCE_INICIAL = 32'd0
) (
  input  logic            Clk,
  input  logic            Reset,
  cajero_arbitro_if.slave bus
);

  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  estado_t     estado_q, estado_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        sel_q, sel_d;      // terminal currently being served
  logic        ptr_q, ptr_d;      // terminal favoured on a tie
  logic [CW-1:0] wait_q, wait_d;
  logic        tipo_q, tipo_d;
  logic [31:0] monto_q, monto_d;
  logic [31:0] res_bal_q, res_bal_d;
  logic        res_fi_q, res_fi_d;
  logic        res_de_q, res_de_d;
  logic [31:0] balance_q, balance_d;
  logic [1:0]  done_q, done_d;
  logic        fi_q, fi_d;
  logic        de_q, de_d;
  logic [1:0]  tmo_q, tmo_d;
  logic        win;

  logic [31:0] alu_bal;
  logic        alu_fi;
  logic        alu_de;

  cajero_alu u_alu (
    .tipo          (tipo_q),
    .monto         (monto_q),
    .balance       (balance_q),
    .nuevo_balance (alu_bal),
    .fondos_insuf  (alu_fi),
    .desborde      (alu_de)
  );

  // Next-state and registered-output computation for the arbiter FSM
  always_comb begin
    estado_d  = estado_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    tipo_d    = tipo_q;
    monto_d   = monto_q;
    res_bal_d = res_bal_q;
    res_fi_d  = res_fi_q;
    res_de_d  = res_de_q;
    balance_d = balance_q;
    done_d    = 2'b00;
    fi_d      = 1'b0;
    de_d      = 1'b0;
    tmo_d     = 2'b00;
    win       = 1'b0;
    case (estado_q)
      IDLE: begin
        if (!bus.BLOQUEO && bus.REQ != 2'b00) begin
          win      = (bus.REQ == 2'b11) ? ptr_q : bus.REQ[1];
          sel_d    = win;
          gnt_d    = win ? 2'b10 : 2'b01;
          wait_d   = '0;
          estado_d = GRANTED;
        end
      end
      GRANTED: begin
        // Dropping the request wins over a same-cycle strobe
        if (!bus.REQ[sel_q]) begin
          gnt_d    = 2'b00;
          ptr_d    = ~sel_q;
          estado_d = IDLE;
        end else if (bus.MONTO_STB[sel_q]) begin
          tipo_d   = bus.TIPO_TRANS[sel_q];
          monto_d  = sel_q ? bus.MONTO_1 : bus.MONTO_0;
          estado_d = EXEC;
        end else if (wait_q == CW'(TIMEOUT_CICLOS - 1)) begin
          tmo_d    = sel_q ? 2'b10 : 2'b01;
          gnt_d    = 2'b00;
          ptr_d    = ~sel_q;
          estado_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EXEC: begin
        res_bal_d = alu_bal;
        res_fi_d  = alu_fi;
        res_de_d  = alu_de;
        gnt_d     = 2'b00;
        estado_d  = RESP;
      end
      RESP: begin
        balance_d = res_bal_q;
        fi_d      = res_fi_q;
        de_d      = res_de_q;
        done_d    = sel_q ? 2'b10 : 2'b01;
        ptr_d     = ~sel_q;
        estado_d  = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; a reset in flight
  // drops any captured amount and restores the initial balance
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      estado_q  <= IDLE;
      gnt_q     <= 2'b00;
      sel_q     <= 1'b0;
      ptr_q     <= 1'b0;
      wait_q    <= '0;
      tipo_q    <= DEPOSITO;
      monto_q   <= 32'd0;
      res_bal_q <= BALANCE_INICIAL;
      res_fi_q  <= 1'b0;
      res_de_q  <= 1'b0;
      balance_q <= BALANCE_INICIAL;
      done_q    <= 2'b00;
      fi_q      <= 1'b0;
      de_q      <= 1'b0;
      tmo_q     <= 2'b00;
    end else begin
      estado_q  <= estado_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      tipo_q    <= tipo_d;
      monto_q   <= monto_d;
      res_bal_q <= res_bal_d;
      res_fi_q  <= res_fi_d;
      res_de_q  <= res_de_d;
      balance_q <= balance_d;
      done_q    <= done_d;
      fi_q      <= fi_d;
      de_q      <= de_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.GNT                  = gnt_q;
  assign bus.DONE                 = done_q;
  assign bus.BALANCE              = balance_q;
  assign bus.FONDOS_INSUFICIENTES = fi_q;
  assign bus.DESBORDE             = de_q;
  assign bus.TIMEOUT              = tmo_q;

endmodule

// File: tb/tb_cajero_arbitro.sv
// Scoreboard bench for cajero_arbitro: stimulus pushes expected grants and
// responses, a monitor pops and compares whenever the DUT presents them.
module tb_cajero_arbitro;
  import cajero_pkg::*;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  tmo;
    logic [31:0] bal;
    logic        fi;
    logic        de;
  } resp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  resp_t resp_q[$];
  int    gnt_q[$];

  cajero_arbitro_if bus ();

  cajero_arbitro #(.TIMEOUT_CICLOS(8), .BALANCE_INICIAL(32'd0)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_done(input int term, input logic [31:0] bal, input logic fi, input logic de);
    resp_t e;
    e.gnt  = 2'b00;
    e.done = (term == 1) ? 2'b10 : 2'b01;
    e.tmo  = 2'b00;
    e.bal  = bal;
    e.fi   = fi;
    e.de   = de;
    resp_q.push_back(e);
  endtask

  // Monitor: grant edges and DONE/TIMEOUT pulses are checked against the queues
  initial begin
    logic [1:0] prev_gnt;
    resp_t      e, a;
    int         g;
    prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.GNT != 2'b00 && prev_gnt == 2'b00) begin
        total++;
        if (gnt_q.size() == 0) begin
          bad++;
          $display("FAIL grant_order: unexpected grant %b", bus.GNT);
        end else begin
          g = gnt_q.pop_front();
          if (bus.GNT !== ((g == 1) ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL grant_order: got %b want terminal %0d", bus.GNT, g);
          end
        end
      end
      prev_gnt = bus.GNT;
      if (bus.DONE != 2'b00 || bus.TIMEOUT != 2'b00) begin
        total++;
        a = {bus.GNT, bus.DONE, bus.TIMEOUT, bus.BALANCE, bus.FONDOS_INSUFICIENTES, bus.DESBORDE};
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL response: unexpected gnt=%b done=%b tmo=%b bal=%0h", a.gnt, a.done, a.tmo, a.bal);
        end else begin
          e = resp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL response: got gnt=%b done=%b tmo=%b bal=%0h fi=%b de=%b want gnt=%b done=%b tmo=%b bal=%0h fi=%b de=%b",
                     a.gnt, a.done, a.tmo, a.bal, a.fi, a.de, e.gnt, e.done, e.tmo, e.bal, e.fi, e.de);
          end
        end
      end
    end
  end

  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0;
    g  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.GNT == 2'b01) begin g = 0; ok = 1'b1; break; end
      if (bus.GNT == 2'b10) begin g = 1; ok = 1'b1; break; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL grant_wait: got no grant want grant within 20 cycles");
    end
  endtask

  // Strobe the amount and check DONE arrives three sampling points later
  task automatic strobe_wait(input int g, input logic tipo, input logic [31:0] m);
    int lat;
    lat = 0;
    bus.TIPO_TRANS[g] = tipo;
    if (g == 0) bus.MONTO_0 = m; else bus.MONTO_1 = m;
    bus.MONTO_STB[g] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.MONTO_STB = 2'b00;
      if (bus.DONE[g]) begin lat = i; break; end
    end
    chk("done_latency", lat, 3);
  endtask

  task automatic do_trans(input int term, input logic tipo, input logic [31:0] m);
    int g;
    bit ok;
    bus.REQ[term] = 1'b1;
    wait_grant(g, ok);
    if (ok) strobe_wait(g, tipo, m);
    bus.REQ[term] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g, cnt;
    bit  ok;
    resp_t e;
    rst_n          = 1'b0;
    bus.REQ        = 2'b00;
    bus.TIPO_TRANS = 2'b00;
    bus.MONTO_0    = 32'd0;
    bus.MONTO_1    = 32'd0;
    bus.MONTO_STB  = 2'b00;
    bus.BLOQUEO    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.GNT), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_tmo", 32'(bus.TIMEOUT), 0);
    chk("rst_bal", bus.BALANCE, 0);
    chk("rst_flags", 32'({bus.FONDOS_INSUFICIENTES, bus.DESBORDE}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic deposit, then insufficient and exact withdrawals
    gnt_q.push_back(0); push_done(0, 32'd100, 0, 0); do_trans(0, DEPOSITO, 32'd100);
    gnt_q.push_back(1); push_done(1, 32'd100, 1, 0); do_trans(1, RETIRO,   32'd150);
    gnt_q.push_back(1); push_done(1, 32'd0,   0, 0); do_trans(1, RETIRO,   32'd100);

    // Overflow boundary
    gnt_q.push_back(0); push_done(0, 32'hFFFF_FFF0, 0, 0); do_trans(0, DEPOSITO, 32'hFFFF_FFF0);
    gnt_q.push_back(0); push_done(0, 32'hFFFF_FFF0, 0, 1); do_trans(0, DEPOSITO, 32'h20);
    gnt_q.push_back(0); push_done(0, 32'hFFFF_FFFF, 0, 0); do_trans(0, DEPOSITO, 32'h0F);
    gnt_q.push_back(1); push_done(1, 32'd0,         0, 0); do_trans(1, RETIRO,   32'hFFFF_FFFF);

    // Both requesting continuously: alternate starting with terminal 0
    gnt_q.push_back(0); push_done(0, 32'd1,  0, 0);
    gnt_q.push_back(1); push_done(1, 32'd3,  0, 0);
    gnt_q.push_back(0); push_done(0, 32'd6,  0, 0);
    gnt_q.push_back(1); push_done(1, 32'd10, 0, 0);
    bus.REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, ok);
      if (!ok) break;
      strobe_wait(g, DEPOSITO, 32'(k + 1));
    end
    bus.REQ = 2'b00;

    // Grant expiry with no strobe
    gnt_q.push_back(0);
    e = '{gnt: 2'b00, done: 2'b00, tmo: 2'b01, bal: 32'd10, fi: 1'b0, de: 1'b0};
    resp_q.push_back(e);
    bus.REQ = 2'b01;
    wait_grant(g, ok);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.TIMEOUT != 2'b00) begin cnt = i; break; end
    end
    bus.REQ = 2'b00;
    chk("timeout_cycles", cnt, 8);

    // Blocked: no grant while BLOQUEO is high
    bus.BLOQUEO = 1'b1;
    bus.REQ     = 2'b01;
    repeat (10) @(negedge clk);
    chk("bloqueo_gnt", 32'(bus.GNT), 0);
    bus.BLOQUEO = 1'b0;
    bus.REQ     = 2'b00;
    @(negedge clk);

    // Release while granted: no DONE, balance untouched
    gnt_q.push_back(1);
    bus.REQ = 2'b10;
    wait_grant(g, ok);
    bus.REQ = 2'b00;
    @(negedge clk);
    chk("release_gnt", 32'(bus.GNT), 0);
    chk("release_bal", bus.BALANCE, 32'd10);

    // BLOQUEO raised mid-transaction: completes, nothing new granted
    gnt_q.push_back(0); push_done(0, 32'd15, 0, 0);
    bus.REQ = 2'b01;
    wait_grant(g, ok);
    bus.BLOQUEO = 1'b1;
    bus.REQ     = 2'b11;
    if (ok) strobe_wait(g, DEPOSITO, 32'd5);
    repeat (5) @(negedge clk);
    chk("bloqueo_mid_gnt", 32'(bus.GNT), 0);
    bus.BLOQUEO = 1'b0;
    bus.REQ     = 2'b00;
    @(negedge clk);

    // Reset while in EXEC: amount discarded, balance back to initial
    gnt_q.push_back(1);
    bus.REQ = 2'b10;
    wait_grant(g, ok);
    bus.TIPO_TRANS[1] = DEPOSITO;
    bus.MONTO_1       = 32'd7;
    bus.MONTO_STB     = 2'b10;
    @(negedge clk);
    bus.MONTO_STB = 2'b00;
    rst_n         = 1'b0;
    @(negedge clk);
    chk("rst_exec_bal", bus.BALANCE, 32'd0);
    chk("rst_exec_gnt", 32'(bus.GNT), 0);
    chk("rst_exec_done", 32'(bus.DONE), 0);
    rst_n   = 1'b1;
    bus.REQ = 2'b00;
    repeat (5) @(negedge clk);

    chk("resp_queue_empty", resp_q.size(), 0);
    chk("gnt_queue_empty", gnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
